// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline stage with a one-entry skid buffer; in_ready comes from a flop.
// Optional saturating stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = {DATA_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);

    // State encoding is {main_v, skid_v}, so each valid bit is a state bit.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_ILLEGAL = 2'b01,
        ST_ONE     = 2'b10,
        ST_FULL    = 2'b11
    } state_e;

    state_e                state_r;
    logic [DATA_WIDTH-1:0] main_d_r;
    logic [DATA_WIDTH-1:0] skid_d_r;
    logic                  in_ready_r;
    logic                  main_v_s;
    logic                  in_hs_s;
    logic                  out_hs_s;

    assign main_v_s  = state_r[1];
    assign in_hs_s   = in_valid & in_ready_r;
    assign out_hs_s  = main_v_s & out_ready;

    assign out_valid = main_v_s;
    assign out_data  = main_d_r;
    assign in_ready  = in_ready_r;

    // Occupancy FSM with main/skid data registers; in_ready_r tracks ~skid_v.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_EMPTY;
            main_d_r   <= RESET_DATA;
            skid_d_r   <= RESET_DATA;
            in_ready_r <= 1'b1;
        end else if (flush) begin
            state_r    <= ST_EMPTY;
            main_d_r   <= RESET_DATA;
            skid_d_r   <= RESET_DATA;
            in_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_hs_s) begin
                        main_d_r <= in_data;
                        state_r  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_hs_s && out_hs_s) begin
                        main_d_r <= in_data;
                    end else if (out_hs_s) begin
                        state_r <= ST_EMPTY;
                    end else if (in_hs_s) begin
                        skid_d_r   <= in_data;
                        state_r    <= ST_FULL;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // Promotion keeps skid_d_r; only its valid bit drops.
                    if (out_hs_s) begin
                        main_d_r   <= skid_d_r;
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_EMPTY;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    assign stall_cycles = stall_cnt_r;

    // Saturating count of cycles where downstream withholds ready; flush leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (main_v_s && !out_ready && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1'b1);
        end
    end
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule
